axil_regif: RTL and testbench
=============================

Name: axil_regif

Overview:
- AXI4-Lite slave that converts AXI-Lite read and write transactions into the simple reg interface: addr/data/strb/en requests, completed by ack.
- Sits directly upstream of the reg-to-APB bridge, so the path is AXI-Lite interconnect -> axil_regif -> reg-to-APB bridge -> APB peripherals.
- Allows one outstanding read and one outstanding write.
- Holds each reg request until ack, then forces at least one idle cycle so the downstream bridge returns to idle.
- A per-channel timeout returns SLVERR if the downstream side never acks.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT, 256, cycles to wait for ack before aborting with SLVERR; 0 disables the timeout.

Ports:
- clk_i  in  1  single clock.
- arst_ni  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awvalid  in  1  / s_axil_awready  out  1  write address handshake.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  write strobes.
- s_axil_wvalid  in  1  / s_axil_wready  out  1  write data handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  / s_axil_bready  in  1  write response handshake.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arvalid  in  1  / s_axil_arready  out  1  read address handshake.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  / s_axil_rready  in  1  read response handshake.
- reg_wr_addr  out  ADDR_WIDTH  / reg_wr_data  out  DATA_WIDTH  / reg_wr_strb  out  STRB_WIDTH  write request payload.
- reg_wr_en  out  1  write request.
- reg_wr_wait  in  1  downstream write stall.
- reg_wr_ack  in  1  write completion.
- reg_rd_addr  out  ADDR_WIDTH  read request address.
- reg_rd_en  out  1  read request.
- reg_rd_data  in  DATA_WIDTH  read data.
- reg_rd_wait  in  1  downstream read stall.
- reg_rd_ack  in  1  read completion.

Behaviour:
- Reset state: all outputs registered and 0, i.e. ready signals, valid signals, en signals, resp, rdata and reg payloads are all 0. Both FSMs are in IDLE.
- Reset asserted mid-transaction drops everything immediately. No response is generated.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
- W_IDLE: AW and W are accepted independently, each into its own one-entry holding register with a valid flag.
  - awready = W_IDLE and AW holder empty.
  - wready = W_IDLE and W holder empty.
  - AW and W may arrive in the same cycle or in either order.
  - When both holders are full, go to W_REQ. reg_wr_en goes to 1 with the held address, data and strobe on the next cycle.
- W_REQ: reg_wr_en and the payload are held stable until reg_wr_ack is sampled high.
  - On ack: reg_wr_en = 0, bvalid = 1, bresp = OKAY (2'b00), holders cleared, go to W_RESP.
- W_RESP: bvalid is held until bready. On the handshake: bvalid = 0, go to W_IDLE.
  - This guarantees reg_wr_en is low for at least 2 cycles between writes.
  - Minimum AW/W-to-B latency: 3 cycles with a combinational ack.
- Read FSM states: R_IDLE, R_REQ, R_RESP.
- R_IDLE: arready = 1. On the AR handshake, latch araddr, go to R_REQ with reg_rd_en = 1. arready = 0 everywhere except R_IDLE.
- R_REQ: reg_rd_en is held until reg_rd_ack.
  - On ack: capture reg_rd_data into rdata, rresp = OKAY, rvalid = 1, reg_rd_en = 0, go to R_RESP.
- R_RESP: rvalid and rdata are held stable until rready. Then go to R_IDLE.
- Ack handling: reg_*_ack is ignored unless the matching FSM is in *_REQ. This covers stray acks from downstream pready while en is low.
- Timeout: a per-channel counter with width $clog2(TIMEOUT+1).
  - Cleared on entering *_REQ.
  - Increments each REQ cycle where wait = 0; frozen while reg_*_wait = 1.
  - When the count reaches TIMEOUT without ack: drop en and respond with SLVERR (2'b10). For reads, rdata = 0.
  - Ack and timeout in the same cycle: ack wins.
- Read and write channels run concurrently. Both en may be high together; the downstream bridge arbitrates.
- AXI valid/ready rules: no output valid depends combinationally on an input ready.

Decomposition:
- Shared package (axil_pkg): AXI resp constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10, plus the FSM state encodings.
- One natural sub-module: axil_regif_tmo, the parameterised timeout counter (inputs clear, run, stall; output expired). It is instantiated once per channel.

Test Plan:
- AW and W in the same cycle (addr 0x10, data 0xDEADBEEF, strb 0xF), ack on the 2nd REQ cycle -> reg_wr_* show exactly those values for 2 cycles, then bvalid with bresp = 0, and reg_wr_en is low before the next request.
- W 5 cycles before AW (addr 0x24) -> wready drops after the W handshake, awready stays high, and reg_wr_en rises one cycle after AW with addr 0x24.
- Read 0x08, downstream acks with rd_data 0x12345678, rready held low 4 cycles -> rvalid and rdata = 0x12345678 held stable, arready = 0 until the R handshake.
- TIMEOUT = 8, no ack, reg_rd_wait high for 3 of the cycles -> rvalid with rresp = 2'b10 and rdata = 0 after 11 REQ cycles; reg_rd_en drops.
- Concurrent read and write, with a stray reg_rd_ack pulse while in R_IDLE -> stray ack ignored, both transactions complete with OKAY.
- arst_ni asserted in W_REQ -> reg_wr_en, bvalid and ready signals are 0 immediately; after release, a fresh write completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite response codes and FSM state encodings for the reg-interface slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axil_regif_tmo.sv
// Ack timeout counter for one channel: counts un-stalled request cycles and
// flags the cycle in which the TIMEOUT-th such cycle is reached.
module axil_regif_tmo #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clear_i,
  input  logic run_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && !stall_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged during the counting cycle itself so the FSM leaves REQ
  // at the end of exactly the TIMEOUT-th un-stalled cycle.
  if (TIMEOUT == 0) begin : g_off
    assign expired_o = 1'b0;
  end else begin : g_on
    assign expired_o = run_i && !stall_i && (cnt_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/axil_regif.sv
// AXI4-Lite slave that turns single read/write transactions into held reg-interface
// requests completed by ack, with a per-channel timeout answering SLVERR.
module axil_regif
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  wr_state_e             w_state_q, w_state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic                  wr_en_q, wr_en_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_expired;

  rd_state_e             r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_expired;

  axil_regif_tmo #(.TIMEOUT(TIMEOUT)) u_wr_tmo (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .clear_i   (w_state_q != W_REQ),
    .run_i     (w_state_q == W_REQ),
    .stall_i   (reg_wr_wait),
    .expired_o (wr_expired)
  );

  axil_regif_tmo #(.TIMEOUT(TIMEOUT)) u_rd_tmo (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .clear_i   (r_state_q != R_REQ),
    .run_i     (r_state_q == R_REQ),
    .stall_i   (reg_rd_wait),
    .expired_o (rd_expired)
  );

  // The AW/W holders double as the reg_wr payload registers.
  always_comb begin
    // NOTE: every next-state signal gets its default before the case so no latch is inferred.
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_en_d   = wr_en_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axil_awvalid && awready_q) begin
          aw_full_d = 1'b1;
          wr_addr_d = s_axil_awaddr;
        end
        if (s_axil_wvalid && wready_q) begin
          w_full_d  = 1'b1;
          wr_data_d = s_axil_wdata;
          wr_strb_d = s_axil_wstrb;
        end
        if (aw_full_q && w_full_q) begin
          w_state_d = W_REQ;
          wr_en_d   = 1'b1;
        end
      end
      W_REQ: begin
        if (reg_wr_ack || wr_expired) begin
          w_state_d = W_RESP;
          wr_en_d   = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = reg_wr_ack ? RESP_OKAY : RESP_SLVERR;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_full_d;
    wready_d  = (w_state_d == W_IDLE) && !w_full_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axil_arvalid && arready_q) begin
          r_state_d = R_REQ;
          rd_addr_d = s_axil_araddr;
          rd_en_d   = 1'b1;
        end
      end
      R_REQ: begin
        if (reg_rd_ack || rd_expired) begin
          r_state_d = R_RESP;
          rd_en_d   = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = reg_rd_ack ? RESP_OKAY : RESP_SLVERR;
          rdata_d   = reg_rd_ack ? reg_rd_data : '0;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      w_state_q <= W_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      wr_en_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      wr_en_q   <= wr_en_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign reg_wr_addr    = wr_addr_q;
  assign reg_wr_data    = wr_data_q;
  assign reg_wr_strb    = wr_strb_q;
  assign reg_wr_en      = wr_en_q;
  assign reg_rd_addr    = rd_addr_q;
  assign reg_rd_en      = rd_en_q;

endmodule

// File: tb/tb_axil_regif.sv
// Directed bench for axil_regif: a transaction-level model (expected reg requests and
// AXI responses, ack timeout counted from the rules) checked every cycle, plus literals.
module tb_axil_regif;
  import axil_pkg::*;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0, s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready = 1'b1;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready = 1'b1;
  logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_rd_en;
  logic        reg_wr_wait = 1'b0, reg_wr_ack = 1'b0;
  logic [31:0] reg_rd_data = '0;
  logic        reg_rd_wait = 1'b0, reg_rd_ack = 1'b0;

  axil_regif #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream responder: ack after N request cycles (0 = never), optional rd stall window.
  int          wr_ack_after = 1, rd_ack_after = 1;
  int          rd_wait_lo = 1, rd_wait_hi = 0;
  logic [31:0] rd_data_cfg = '0;
  logic        stray_rd = 1'b0;
  int          wr_n = 0, rd_n = 0;

  initial forever begin
    @(negedge clk_i);
    if (!arst_ni) begin
      wr_n = 0; rd_n = 0; reg_wr_ack = 1'b0; reg_rd_ack = 1'b0; reg_rd_wait = 1'b0;
    end else begin
      if (reg_wr_en) begin
        wr_n++;
        reg_wr_ack = (wr_ack_after > 0) && (wr_n == wr_ack_after);
      end else begin
        wr_n = 0;
        reg_wr_ack = 1'b0;
      end
      if (reg_rd_en) begin
        rd_n++;
        reg_rd_ack  = (rd_ack_after > 0) && (rd_n == rd_ack_after);
        reg_rd_wait = (rd_n >= rd_wait_lo) && (rd_n <= rd_wait_hi);
        reg_rd_data = rd_data_cfg;
      end else begin
        rd_n = 0;
        reg_rd_ack  = stray_rd;
        reg_rd_wait = 1'b0;
      end
    end
  end

  // Transaction-level model.
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wreq_t;
  typedef struct { logic [1:0] resp; logic [31:0] data; } rrsp_t;

  wreq_t       exp_wr[$];
  logic [1:0]  exp_b[$];
  logic [31:0] exp_rd[$];
  rrsp_t       exp_r[$];
  logic        aw_held = 0, w_held = 0, wr_busy = 0, rd_busy = 0, alive = 0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_strb;
  int          wr_nw = 0, rd_nw = 0;
  logic        b_done, r_done;

  initial forever begin
    @(posedge clk_i);
    alive = arst_ni;
  end

  initial forever begin
    @(negedge clk_i);
    #2;
    if (!arst_ni) begin
      exp_wr.delete(); exp_b.delete(); exp_rd.delete(); exp_r.delete();
      aw_held = 0; w_held = 0; wr_busy = 0; rd_busy = 0; wr_nw = 0; rd_nw = 0;
    end else begin
      b_done = 0;
      r_done = 0;
      check("bvalid", s_axil_bvalid, exp_b.size() > 0);
      if (s_axil_bvalid && exp_b.size() > 0) begin
        check("bresp", s_axil_bresp, exp_b[0]);
        if (s_axil_bready) begin void'(exp_b.pop_front()); b_done = 1; end
      end
      check("rvalid", s_axil_rvalid, exp_r.size() > 0);
      if (s_axil_rvalid && exp_r.size() > 0) begin
        check("rresp", s_axil_rresp, exp_r[0].resp);
        check("rdata", s_axil_rdata, exp_r[0].data);
        if (s_axil_rready) begin void'(exp_r.pop_front()); r_done = 1; end
      end
      check("reg_wr_en", reg_wr_en, exp_wr.size() > 0);
      if (reg_wr_en && exp_wr.size() > 0) begin
        check("reg_wr_addr", reg_wr_addr, exp_wr[0].addr);
        check("reg_wr_data", reg_wr_data, exp_wr[0].data);
        check("reg_wr_strb", reg_wr_strb, exp_wr[0].strb);
        if (reg_wr_ack) begin
          void'(exp_wr.pop_front()); exp_b.push_back(RESP_OKAY);
        end else if (!reg_wr_wait && ++wr_nw == TMO) begin
          void'(exp_wr.pop_front()); exp_b.push_back(RESP_SLVERR);
        end
      end
      check("reg_rd_en", reg_rd_en, exp_rd.size() > 0);
      if (reg_rd_en && exp_rd.size() > 0) begin
        check("reg_rd_addr", reg_rd_addr, exp_rd[0]);
        if (reg_rd_ack) begin
          void'(exp_rd.pop_front()); exp_r.push_back('{RESP_OKAY, reg_rd_data});
        end else if (!reg_rd_wait && ++rd_nw == TMO) begin
          void'(exp_rd.pop_front()); exp_r.push_back('{RESP_SLVERR, 32'h0});
        end
      end
      if (alive) begin
        check("awready", s_axil_awready, !wr_busy && !aw_held);
        check("wready", s_axil_wready, !wr_busy && !w_held);
        check("arready", s_axil_arready, !rd_busy);
      end
      // Both holders full: the request appears on the following cycle.
      if (aw_held && w_held) begin
        exp_wr.push_back('{h_addr, h_data, h_strb});
        wr_busy = 1; aw_held = 0; w_held = 0; wr_nw = 0;
      end
      if (s_axil_awvalid && s_axil_awready) begin aw_held = 1; h_addr = s_axil_awaddr; end
      if (s_axil_wvalid && s_axil_wready) begin w_held = 1; h_data = s_axil_wdata; h_strb = s_axil_wstrb; end
      if (s_axil_arvalid && s_axil_arready) begin
        exp_rd.push_back(s_axil_araddr); rd_busy = 1; rd_nw = 0;
      end
      if (b_done) wr_busy = 0;
      if (r_done) rd_busy = 0;
    end
  end

  // AXI master helpers; all start and end at posedge+1.
  task automatic do_aw(input logic [31:0] addr);
    bit ok = 0;
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (s_axil_awready) begin ok = 1; break; end
    end
    check("aw_handshake", ok, 1);
    @(posedge clk_i); #1;
    s_axil_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb);
    bit ok = 0;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (s_axil_wready) begin ok = 1; break; end
    end
    check("w_handshake", ok, 1);
    @(posedge clk_i); #1;
    s_axil_wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr);
    bit ok = 0;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (s_axil_arready) begin ok = 1; break; end
    end
    check("ar_handshake", ok, 1);
    @(posedge clk_i); #1;
    s_axil_arvalid = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (s_axil_bvalid) begin ok = 1; resp = s_axil_bresp; break; end
    end
    check("b_arrival", ok, 1);
    @(posedge clk_i); #1;
  endtask

  task automatic get_r(output logic [1:0] resp, output logic [31:0] data);
    bit ok = 0;
    resp = 2'bxx; data = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (s_axil_rvalid) begin ok = 1; resp = s_axil_rresp; data = s_axil_rdata; break; end
    end
    check("r_arrival", ok, 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int lat, en_n, req_n;

    arst_ni = 1'b1;
    #1 arst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    check("rst_valid", {s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en}, 4'b0000);
    check("rst_payload", {reg_wr_addr, reg_wr_data} | {reg_rd_addr, s_axil_rdata}, 64'h0);
    check("rst_resp", {reg_wr_strb, s_axil_bresp, s_axil_rresp}, 8'h00);
    arst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // AW+W together, ack on the 2nd request cycle: 2 en cycles, B on the 4th cycle.
    wr_ack_after = 2;
    fork
      do_aw(32'h10);
      do_w(32'hDEADBEEF, 4'hF);
    join
    lat = 0; en_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i); #1;
      if (reg_wr_en) begin
        en_n++;
        check("s1_wr_data", reg_wr_data, 32'hDEADBEEF);
      end
      if (s_axil_bvalid) begin lat = i; break; end
    end
    check("s1_b_latency", lat, 4);
    check("s1_en_cycles", en_n, 2);
    check("s1_bresp", s_axil_bresp, RESP_OKAY);
    @(posedge clk_i); #1;

    // W five cycles ahead of AW.
    wr_ack_after = 1;
    do_w(32'h0BADF00D, 4'h3);
    @(negedge clk_i); #1;
    check("s2_wready_after_w", s_axil_wready, 0);
    check("s2_awready_after_w", s_axil_awready, 1);
    repeat (4) @(posedge clk_i);
    #1;
    do_aw(32'h24);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i); #1;
      if (reg_wr_en) begin lat = i; break; end
    end
    check("s2_en_delay", lat, 2);
    check("s2_wr_addr", reg_wr_addr, 32'h24);
    get_b(resp);
    check("s2_bresp", resp, RESP_OKAY);

    // Read with back-pressure on R.
    rd_ack_after = 1; rd_data_cfg = 32'h12345678; s_axil_rready = 1'b0;
    do_ar(32'h08);
    get_r(resp, data);
    check("s3_rdata", data, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      check("s3_rvalid_held", s_axil_rvalid, 1);
      check("s3_rdata_held", s_axil_rdata, 32'h12345678);
      check("s3_arready_low", s_axil_arready, 0);
      @(posedge clk_i); #1;
    end
    s_axil_rready = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i); #1;
    check("s3_rvalid_done", s_axil_rvalid, 0);
    check("s3_arready_back", s_axil_arready, 1);
    @(posedge clk_i); #1;

    // Read timeout: 8 counting cycles plus 3 stalled cycles.
    rd_ack_after = 0; rd_wait_lo = 3; rd_wait_hi = 5; rd_data_cfg = 32'hFFFFFFFF;
    do_ar(32'h0C);
    req_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i); #1;
      if (reg_rd_en) req_n++;
      if (s_axil_rvalid) break;
    end
    check("s4_req_cycles", req_n, 11);
    check("s4_rresp", s_axil_rresp, RESP_SLVERR);
    check("s4_rdata", s_axil_rdata, 32'h0);
    check("s4_rd_en_dropped", reg_rd_en, 0);
    @(posedge clk_i); #1;
    rd_wait_lo = 1; rd_wait_hi = 0;

    // Stray read ack in R_IDLE, then concurrent read and write.
    rd_ack_after = 2; rd_data_cfg = 32'hCAFE0001; wr_ack_after = 1;
    stray_rd = 1'b1;
    @(posedge clk_i); #1;
    stray_rd = 1'b0;
    @(negedge clk_i); #1;
    check("s5_stray_ignored", s_axil_rvalid, 0);
    @(posedge clk_i); #1;
    fork
      begin
        logic [1:0]  rr;
        logic [31:0] rd;
        do_ar(32'h40);
        get_r(rr, rd);
        check("s5_rresp", rr, RESP_OKAY);
        check("s5_rdata", rd, 32'hCAFE0001);
      end
      begin
        logic [1:0] br;
        fork
          do_aw(32'h30);
          do_w(32'hA5A50F0F, 4'hC);
        join
        get_b(br);
        check("s5_bresp", br, RESP_OKAY);
      end
    join

    // Reset while a write sits in W_REQ, then a fresh write.
    wr_ack_after = 0;
    fork
      do_aw(32'h50);
      do_w(32'h11223344, 4'h1);
    join
    repeat (3) @(posedge clk_i);
    #1;
    check("s6_in_req", reg_wr_en, 1);
    arst_ni = 1'b0;
    #1;
    check("s6_rst_en", {reg_wr_en, reg_rd_en}, 2'b00);
    check("s6_rst_valid", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    check("s6_rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    repeat (2) @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
    wr_ack_after = 1;
    fork
      do_aw(32'h54);
      do_w(32'h55667788, 4'hF);
    join
    get_b(resp);
    check("s6_fresh_bresp", resp, RESP_OKAY);

    repeat (4) @(posedge clk_i);
    #1;
    check("model_drained", exp_wr.size() + exp_b.size() + exp_rd.size() + exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
